// File: rtl/riscv_inst_encoder.sv
// Streaming I/S/J instruction encoder with a 2-entry write queue toward instruction memory.
// Optional RISCV_ENC_RANGE_CHECK_EN: flags immediates that the chosen format cannot represent.
module riscv_inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_imm,
  output logic        wr_en,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        restart,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_S   = 2'b01,
    FMT_J   = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  fmt_e        fmt;
  logic [31:0] enc_word;
  logic        range_err;
  logic [31:0] q [2];
  logic [1:0]  count;
  logic        accept;
  logic        push;
  logic        pop;
  logic        err_set;

  assign fmt = fmt_e'(in_fmt);

  always_comb begin
    enc_word = '0;
    case (fmt)
      FMT_I:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S:   enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_J:   enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: enc_word = '0;
    endcase
  end

`ifdef RISCV_ENC_RANGE_CHECK_EN
  // Representable iff the bits dropped by packing are all copies of the sign bit.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      FMT_J:        range_err = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
      default:      range_err = 1'b0;
    endcase
  end
`else
  logic unused_imm;
  assign range_err  = 1'b0;
  assign unused_imm = ^{in_imm[31:21], in_imm[0]};
`endif

  assign wr_en    = (count != 2'd0);
  assign wr_data  = wr_en ? q[0] : '0;
  assign in_ready = (count != 2'd2) && !restart;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (fmt != FMT_RSV);
  assign pop      = wr_en && wr_ready && !restart;
  assign err_set  = accept && ((fmt == FMT_RSV) || range_err);

  // q[0] is always the head; a pop shifts q[1] down so wr_data needs no read mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      wr_addr <= BASE_ADDR;
      q[0]    <= '0;
      q[1]    <= '0;
    end else if (restart) begin
      count   <= '0;
      wr_addr <= BASE_ADDR;
    end else begin
      if (pop) wr_addr <= wr_addr + 32'd4;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) q[0] <= enc_word;
          else               q[1] <= enc_word;
          count <= count + 2'd1;
        end
        2'b01: begin
          q[0]  <= q[1];
          count <= count - 2'd1;
        end
        2'b11:   q[0] <= enc_word;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Scoreboard bench for riscv_inst_encoder: directed encodings, backpressure, restart,
// error flag handling, then randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_riscv_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        wr_en;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        restart;
  logic        err;
  logic        err_clr;

  riscv_inst_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .restart(restart), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          model_cnt;
  logic [31:0] model_addr;
  logic [31:0] push_addr;
  logic        model_err;
  logic        use_ovr;
  logic [31:0] ovr_word;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference packing built from shifts and masks of the immediate value.
  function automatic logic [31:0] enc_model(input logic [1:0] f, input logic [31:0] op,
      input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] f3, input logic [31:0] imm);
    case (f)
      2'd0: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      2'd1: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((imm & 32'h1F) << 7) | op;
      2'd2: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (rd << 7) | op;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit range_bad(input logic [1:0] f, input logic [31:0] imm);
`ifdef RISCV_ENC_RANGE_CHECK_EN
    int s;
    s = signed'(imm);
    if (f == 2'd0 || f == 2'd1) return (s < -2048) || (s > 2047);
    if (f == 2'd2) return ((s % 2) != 0) || (s < -(1 << 20)) || (s >= (1 << 20));
    return 1'b0;
`else
    return (f == 2'd3) && (imm == 32'h0) && 1'b0;
`endif
  endfunction

  task automatic model_reset();
    model_cnt  = 0;
    model_addr = BASE;
    push_addr  = BASE;
    model_err  = 1'b0;
    sb.delete();
  endtask

  // One clock: compare registered outputs, then advance the model by this cycle's inputs.
  task automatic tick(output bit acc);
    bit exp_ready, pop_m, push_m, set_m;
    logic [31:0] w;
    @(negedge clk); #1;
    exp_ready = (model_cnt < 2) && !restart;
    check1("in_ready", in_ready, exp_ready);
    check1("wr_en", wr_en, model_cnt > 0);
    check32("wr_addr", wr_addr, model_addr);
    check1("err", err, model_err);
    acc    = in_valid && exp_ready;
    pop_m  = (model_cnt > 0) && wr_ready && !restart;
    push_m = acc && (in_fmt != 2'd3);
    set_m  = acc && ((in_fmt == 2'd3) || range_bad(in_fmt, in_imm));
    if (restart) begin
      model_cnt  = 0;
      model_addr = BASE;
      push_addr  = BASE;
      sb.delete();
    end else begin
      if (push_m) begin
        w = use_ovr ? ovr_word
                    : enc_model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
        sb.push_back('{addr: push_addr, data: w});
        push_addr += 32'd4;
      end
      model_cnt = model_cnt + int'(push_m) - int'(pop_m);
      if (pop_m) model_addr += 32'd4;
    end
    if (set_m)        model_err = 1'b1;
    else if (err_clr) model_err = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    repeat (n) tick(a);
  endtask

  task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [31:0] imm, input logic ovr, input logic [31:0] word);
    bit a;
    int waited;
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm; use_ovr = ovr; ovr_word = word;
    in_valid = 1'b1;
    a = 1'b0;
    waited = 0;
    while (!a && waited < 40) begin
      tick(a);
      waited++;
    end
    n_vec++;
    if (!a) begin
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 40 cycles");
    end
    in_valid = 1'b0;
    use_ovr  = 1'b0;
  endtask

  // Monitor: every presented word must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL wr_unexpected: got write %08h@%08h expected no write", wr_data, wr_addr);
      end else begin
        check32("wr_data", wr_data, sb[0].data);
        check32("wr_addr_mon", wr_addr, sb[0].addr);
        if (wr_ready && !restart) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_funct3 = '0; in_imm = '0; wr_ready = 1'b1; restart = 1'b0;
    err_clr = 1'b0; use_ovr = 1'b0; ovr_word = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_wr_en", wr_en, 1'b0);
    check32("rst_wr_addr", wr_addr, BASE);
    check32("rst_wr_data", wr_data, 32'h0);
    check1("rst_err", err, 1'b0);
    rst = 1'b0;

    // addi x1, x0, -1
    send(2'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0093);
    idle(2);

    // restart with empty queue, then sw / jal / jal back-to-back from BASE
    restart = 1'b1; idle(1); restart = 1'b0;
    send(2'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'h0000_0008, 1'b1, 32'h0020_A423);
    send(2'd2, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 1'b1, 32'h0010_00EF);
    send(2'd2, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 1'b1, 32'hFFDF_F06F);
    idle(3);

    // backpressure: two accepts fill the queue, third waits until drain
    wr_ready = 1'b0;
    send(2'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd1, 32'h0000_0123, 1'b0, 32'h0);
    send(2'd1, 7'h23, 5'd0, 5'd5, 5'd6, 3'd2, 32'hFFFF_FFF0, 1'b0, 32'h0);
    fork
      send(2'd2, 7'h6F, 5'd7, 5'd0, 5'd0, 3'd0, 32'h0001_2346, 1'b0, 32'h0);
      begin
        repeat (4) @(posedge clk);
        #1 wr_ready = 1'b1;
      end
    join
    idle(3);

    // restart with two queued words
    wr_ready = 1'b0;
    send(2'd0, 7'h13, 5'd8, 5'd9, 5'd0, 3'd0, 32'h0000_0010, 1'b0, 32'h0);
    send(2'd0, 7'h13, 5'd10, 5'd11, 5'd0, 3'd0, 32'h0000_0020, 1'b0, 32'h0);
    in_valid = 1'b1; restart = 1'b1;
    begin bit a; tick(a); end
    in_valid = 1'b0; restart = 1'b0;
    wr_ready = 1'b1;
    idle(2);

    // reserved format, err clear, and set-beats-clear
    send(2'd3, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 32'h0, 1'b0, 32'h0);
    idle(2);
    err_clr = 1'b1; idle(1); err_clr = 1'b0; idle(1);
    err_clr = 1'b1;
    send(2'd3, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 32'h0, 1'b0, 32'h0);
    err_clr = 1'b0;
    idle(2);
    err_clr = 1'b1; idle(1); err_clr = 1'b0; idle(1);

    // out-of-range I immediate: truncated word is still written
    send(2'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 1'b1, 32'h8000_0013);
    idle(2);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;

    // asynchronous reset with words queued
    wr_ready = 1'b0;
    send(2'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'h0000_0044, 1'b0, 32'h0);
    send(2'd2, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0100, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check1("async_rst_wr_en", wr_en, 1'b0);
    check32("async_rst_wr_addr", wr_addr, BASE);
    check32("async_rst_wr_data", wr_data, 32'h0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    wr_ready = 1'b1;
    idle(1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit a;
      int sel;
      wr_ready  = ($urandom_range(0, 3) != 0);
      restart   = ($urandom_range(0, 24) == 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_fmt    = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      in_opcode = 7'($urandom);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
        0: in_imm = $urandom;
        1: in_imm = 32'(signed'(12'($urandom)));
        2: in_imm = 32'(signed'(21'($urandom))) & 32'hFFFF_FFFE;
        default: begin
          logic [31:0] edges [7];
          edges = '{32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0800, 32'hFFFF_F7FF,
                    32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000};
          in_imm = edges[$urandom_range(0, 6)];
        end
      endcase
      tick(a);
    end
    restart = 1'b0; err_clr = 1'b0; wr_ready = 1'b1;
    idle(5);
    check32("drain_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
